mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the single-cycle CPU.
- Accepts MULT/MULTU/DIV/DIVU from the decode stage and runs a 32-step shift-add or restoring-divide loop on one shared adder.
- Raises busy so the CPU stalls on MFHI/MFLO/MTHI/MTLO/MDU ops.
- Also services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- STEPS, 32, CALC iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request new operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- hilo_we  input  1  MTHI/MTLO write strobe.
- hilo_sel  input  1  0 = LO, 1 = HI target for hilo_we.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight; CPU must stall.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rstn=0, async): state IDLE; busy=0, done=0, hi=0, lo=0; internal shift/accumulator registers cleared.
- Reset mid-operation aborts immediately; no partial result is written.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on edge E0 with start=1:
  - Latch |a|, |b| (signed ops) or raw a, b (unsigned ops).
  - Record result signs.
  - Load step counter = STEPS.
- Divide by zero: IDLE -> DONE directly at E0. hi/lo unchanged; done high after E0.
- CALC: one iteration per edge, counter decrements.
  - Multiply: 64-bit product register, add-if-LSB then shift right.
  - Divide: restoring divide; shift remainder:quotient left, trial subtract, set quotient bit if non-negative.
  - After the STEPS-th iteration (edge E32), go to FIX.
- FIX (edge E33):
  - Apply two's-complement sign correction.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Write hi/lo: mult: hi = product[63:32], lo = product[31:0]; div: lo = quotient, hi = remainder.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge. busy=0 from that edge.
- Latency, normal path:
  - busy high from after E0 through the cycle after E33.
  - done high in the cycle after E33.
  - busy falls at E34.
- Signed division truncates toward zero. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no exception.
- start while busy: ignored, with no queueing.
- hilo_we while busy: ignored.
- hilo_we in IDLE: target register updated at the next edge.
- start and hilo_we in the same IDLE cycle: start wins; the write is dropped.
- hi/lo are stable at all times except the FIX edge, a write edge, or reset.

Optional Feature:
- Macro: MDU_EARLY_EXIT_EN.
- Defined, multiply ops only: CALC ends when the remaining multiplier shift register is zero. Product alignment is fixed in FIX.
  - CALC length N = max(1, index of highest set bit of latched multiplier + 1).
  - done is high in the cycle after edge E(N+1).
  - Divide latency is unchanged.
- Undefined: every operation uses the full STEPS cycles, as specified above.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after start; busy high 34 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI wdata=0x12345678, then DIVU a=9, b=0 -> done after 1 cycle; hi=0x12345678 and lo unchanged. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/7 running, second start (MULTU 2*3) plus hilo_we at cycle 10 -> both ignored; result lo=14, hi=2.
- rstn low at cycle 15 of a MULTU -> busy=0, done=0, hi=lo=0 asynchronously; no done pulse after release.
- With MDU_EARLY_EXIT_EN: MULTU 3*5 -> lo=15, hi=0, done in the cycle after E4. Without the macro, done is in the cycle after E33.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Purpose : bundles the decode-stage <-> multiply/divide unit signals.
// Ports   : start/op/a/b request, hilo_we/hilo_sel/wdata MTHI/MTLO write,
//           busy/done status, hi/lo result registers.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_we;
    logic             hilo_sel;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // CPU / decode side
    modport master (
        output start, op, a, b, hilo_we, hilo_sel, wdata,
        input  busy, done, hi, lo
    );

    // multiply/divide unit side
    modport slave (
        input  start, op, a, b, hilo_we, hilo_sel, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair (one shared adder).
// Latency : result in HI/LO and done pulse in the cycle after the FIX edge (STEPS+1 edges after start).
// Backpr. : busy high while an op is in flight; start and hilo_we are ignored (not queued) while busy.
// Ports   : clk, rstn (async active-low); bus (mdu_seq_if.slave): start/op/a/b request,
//           hilo_we/hilo_sel/wdata MTHI/MTLO write, busy/done status, hi/lo outputs.
// Config  : define MDU_EARLY_EXIT_EN to end multiply CALC once the remaining multiplier bits are zero.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32    // must equal WIDTH
) (
    input  logic     clk,
    input  logic     rstn,
    mdu_seq_if.slave bus
);
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier+product low half / dividend+quotient
    logic [WIDTH-1:0] bop;      // multiplicand / divisor magnitude
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;    // negate product or quotient in FIX
    logic             neg_r;    // negate remainder in FIX
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_c, done_c;

    // request decode: op[0]=0 is signed, op[1]=1 is divide
    logic             op_signed, op_div, div_zero;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign op_signed = ~bus.op[0];
    assign op_div    = bus.op[1];
    assign div_zero  = op_div && (bus.b == '0);
    assign a_abs     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef MDU_EARLY_EXIT_EN
    // iterations needed = index of highest set multiplier bit + 1, at least one
    logic [CW-1:0] n_mul;
    logic [CW-1:0] align;       // product sits this many bits too far left after early exit
    always_comb begin
        n_mul = CW'(1);
        for (int i = 0; i < WIDTH; i++) begin
            if (b_abs[i]) n_mul = CW'(i + 1);
        end
    end
`endif

    // shared adder: multiply adds the multiplicand when the multiplier LSB is set,
    // divide trial-subtracts the divisor from the left-shifted remainder
    logic [WIDTH:0] add_x, add_y, add_sum;
    logic           add_sub;
    always_comb begin
        add_x   = {1'b0, acc};
        add_y   = mq[0] ? {1'b0, bop} : '0;
        add_sub = 1'b0;
        if (is_div) begin
            add_x   = {acc, mq[WIDTH-1]};
            add_y   = {1'b0, bop};
            add_sub = 1'b1;
        end
        add_sum = add_x + (add_sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, add_sub};
    end

    // sign correction applied on the FIX edge
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    always_comb begin
        prod = {acc, mq};
`ifdef MDU_EARLY_EXIT_EN
        // unconsumed multiplier bits in the low end are zero, so a plain shift realigns
        prod = prod >> align;
`endif
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -mq   : mq;
        rem_fix  = neg_r ? -acc  : acc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) state_nxt = div_zero ? DONE : CALC;
            end
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc    <= '0;
            mq     <= '0;
            bop    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`ifdef MDU_EARLY_EXIT_EN
            align  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    acc    <= '0;
                    is_div <= op_div;
                    neg_q  <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_r  <= op_signed && bus.a[WIDTH-1];
                    cnt    <= CW'(STEPS);
`ifdef MDU_EARLY_EXIT_EN
                    align  <= '0;
`endif
                    if (op_div) begin
                        mq  <= a_abs;
                        bop <= b_abs;
                    end else begin
                        mq  <= b_abs;
                        bop <= a_abs;
`ifdef MDU_EARLY_EXIT_EN
                        cnt   <= n_mul;
                        align <= CW'(STEPS) - n_mul;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        // non-negative trial difference: keep it and set the quotient bit
                        if (!add_sum[WIDTH]) begin
                            acc <= add_sum[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= add_x[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= add_sum[WIDTH:1];
                        mq  <= {add_sum[0], mq[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // HI/LO change only on the FIX edge or an idle MTHI/MTLO; start beats a same-cycle write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            if (is_div) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                lo_q <= prod_fix[WIDTH-1:0];
            end
        end else if (state == IDLE && !bus.start && bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.wdata;
            else              lo_q <= bus.wdata;
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Purpose : directed self-checking bench for mdu_seq (multiply, divide, HI/LO writes, reset abort).
// Timing  : inputs driven and outputs sampled 1 time unit after each rising edge.
// Flow    : linear sequence of directed steps; summary line printed at the end.
module tb_mdu_seq;
    logic clk;
    logic rstn;
    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32), .STEPS(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;

`ifdef MDU_EARLY_EXIT_EN
    localparam int LAT_3X5 = 4;
`else
    localparam int LAT_3X5 = 33;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = edges after E0 until done is seen (E33 -> 33); bcnt = cycles with busy high
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start   = 1'b0;
        bus.hilo_we = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        if (bus.busy === 1'b1) bcnt++;
    endtask

    initial begin
        int lat, bcnt, k, dones;
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.a        = '0;
        bus.b        = '0;
        bus.hilo_we  = 1'b0;
        bus.hilo_sel = 1'b0;
        bus.wdata    = '0;
        #12;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        rstn = 1'b1;
        tick();

        // MULTU max * max
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_lat", lat, 32'd33);
        check("multu_busy_cycles", bcnt, 32'd34);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);
        tick();
        check("multu_busy_after", {31'd0, bus.busy}, 32'd0);
        check("multu_done_after", {31'd0, bus.done}, 32'd0);

        // MULT -3 * 5
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);
        tick();

        // DIV -7 / 2 truncates toward zero
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_neg_lat", lat, 32'd33);
        check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        tick();

        // MTHI in idle
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = 1'b1;
        bus.wdata    = 32'h1234_5678;
        tick();
        bus.hilo_we = 1'b0;
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo_kept", bus.lo, 32'hFFFF_FFFD);

        // DIVU by zero: straight to DONE, HI/LO untouched
        do_op(2'b11, 32'd9, 32'd0, lat, bcnt);
        check("div0_lat", lat, 32'd0);
        check("div0_busy_cycles", bcnt, 32'd1);
        check("div0_hi", bus.hi, 32'h1234_5678);
        check("div0_lo", bus.lo, 32'hFFFF_FFFD);
        tick();
        check("div0_idle", {31'd0, bus.busy}, 32'd0);

        // DIV most-negative / -1
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        check("div_ovf_hi", bus.hi, 32'h0);
        tick();

        // DIVU 100/7 with a second start and a write arriving mid-operation
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 200) begin
            if (k == 10) begin
                bus.start    = 1'b1;
                bus.op       = 2'b01;
                bus.a        = 32'd2;
                bus.b        = 32'd3;
                bus.hilo_we  = 1'b1;
                bus.hilo_sel = 1'b0;
                bus.wdata    = 32'hDEAD_BEEF;
            end
            if (k == 20) begin
                check("busy_hold_hi", bus.hi, 32'h0);
                check("busy_hold_lo", bus.lo, 32'h8000_0000);
            end
            tick();
            if (k == 10) begin
                bus.start   = 1'b0;
                bus.hilo_we = 1'b0;
            end
            k++;
        end
        check("divu_ign_lat", k, 32'd33);
        check("divu_ign_lo", bus.lo, 32'd14);
        check("divu_ign_hi", bus.hi, 32'd2);
        tick();
        tick();
        check("divu_no_queue", {31'd0, bus.busy}, 32'd0);

        // start and hilo_we together in idle: start wins
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = 1'b1;
        bus.wdata    = 32'hAAAA_AAAA;
        do_op(2'b01, 32'd2, 32'd3, lat, bcnt);
        check("start_wins_hi", bus.hi, 32'h0);
        check("start_wins_lo", bus.lo, 32'd6);
        tick();

        // MTLO in idle
        bus.hilo_we  = 1'b1;
        bus.hilo_sel = 1'b0;
        bus.wdata    = 32'h55AA_55AA;
        tick();
        bus.hilo_we = 1'b0;
        check("mtlo_lo", bus.lo, 32'h55AA_55AA);
        check("mtlo_hi_kept", bus.hi, 32'h0);

        // MULTU 3*5: short multiplier
        do_op(2'b01, 32'd3, 32'd5, lat, bcnt);
        check("mul_3x5_lat", lat, LAT_3X5);
        check("mul_3x5_lo", bus.lo, 32'd15);
        check("mul_3x5_hi", bus.hi, 32'd0);
        tick();

        // asynchronous reset in the middle of a MULTU
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        #3;
        rstn = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        check("abort_lo_after", bus.lo, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
